// File: rtl/flash_arbiter.sv
// Round-robin arbiter sharing the flash controller word-read port between two masters.
// One transaction in flight; sequences read_op/bus_stall and aborts hung reads on timeout.
module flash_arbiter #(
    parameter int unsigned ADDR_W         = 23,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] fc_addr,
    output logic              fc_read,
    input  logic [DATA_W-1:0] fc_rdata,
    input  logic              fc_stall,
    output logic              err_timeout
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StResp
    } state_t;

    state_t          state;
    logic            grant_id;   // 0 = m0, 1 = m1
    logic            last_grant;
    logic [CntW-1:0] tmo_cnt;
    logic            pick_m1;
    logic            tmo_hit;

    // Round-robin choice: a lone requester wins, a tie goes to the port not served last.
    assign pick_m1 = m1_req && (!m0_req || !last_grant);
    assign tmo_hit = (tmo_cnt == TmoLast);

    // Transaction sequencer; every output is a register of this block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            fc_addr     <= '0;
            fc_read     <= 1'b0;
            m0_rdata    <= '0;
            m0_ack      <= 1'b0;
            m1_rdata    <= '0;
            m1_ack      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    // Never start while the controller is still busy with anything.
                    if (!fc_stall && (m0_req || m1_req)) begin
                        grant_id   <= pick_m1;
                        last_grant <= pick_m1;
                        fc_addr    <= pick_m1 ? m1_addr : m0_addr;
                        fc_read    <= 1'b1;
                        state      <= StIssue;
                    end
                end

                StIssue: begin
                    fc_read <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= StWaitBusy;
                end

                StWaitBusy, StWaitDone: begin
                    if (tmo_hit) begin
                        // Hung controller: complete the granted master with zero data.
                        if (grant_id) begin
                            m1_rdata <= '0;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= '0;
                            m0_ack   <= 1'b1;
                        end
                        err_timeout <= 1'b1;
                        state       <= StResp;
                    end else begin
                        tmo_cnt <= tmo_cnt + CntW'(1);
                        if (state == StWaitBusy) begin
                            if (fc_stall) begin
                                state <= StWaitDone;
                            end
                        end else if (!fc_stall) begin
                            if (grant_id) begin
                                m1_rdata <= fc_rdata;
                                m1_ack   <= 1'b1;
                            end else begin
                                m0_rdata <= fc_rdata;
                                m0_ack   <= 1'b1;
                            end
                            state <= StResp;
                        end
                    end
                end

                StResp: begin
                    // Requests are ignored here so a held req is re-sampled fresh in idle.
                    m0_ack      <= 1'b0;
                    m1_ack      <= 1'b0;
                    err_timeout <= 1'b0;
                    state       <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
